// File: rtl/dqsw_level_trainer_if.sv
// Bundle between the DDR PHY training controller, the write-leveling trainer
// and the lane's DQSW training IOD.
// Optional macro DQSW_EYE_QUAL_EN adds the eye_qual_drops counter.
// The master side is the controller/IOD environment; the trainer uses the slave side.
interface dqsw_level_trainer_if #(
    parameter int unsigned TAP_W = 7
);
    // Controller handshake
    logic             train_start;
    logic             train_busy;
    logic             train_done;
    logic             train_fail;
    logic [TAP_W-1:0] train_tap;
    // IOD feedback
    logic [1:0]       rx_data;
    logic             eye_early;
    logic             eye_late;
    logic             delay_out_of_range;
    // IOD control
    logic             delay_line_load;
    logic             delay_line_move;
    logic             delay_line_direction;
    logic             eye_monitor_clear_flags;
`ifdef DQSW_EYE_QUAL_EN
    logic [7:0]       eye_qual_drops;

    modport master (
        output train_start, rx_data, eye_early, eye_late, delay_out_of_range,
        input  train_busy, train_done, train_fail, train_tap, delay_line_load,
               delay_line_move, delay_line_direction, eye_monitor_clear_flags, eye_qual_drops
    );

    modport slave (
        input  train_start, rx_data, eye_early, eye_late, delay_out_of_range,
        output train_busy, train_done, train_fail, train_tap, delay_line_load,
               delay_line_move, delay_line_direction, eye_monitor_clear_flags, eye_qual_drops
    );
`else
    modport master (
        output train_start, rx_data, eye_early, eye_late, delay_out_of_range,
        input  train_busy, train_done, train_fail, train_tap, delay_line_load,
               delay_line_move, delay_line_direction, eye_monitor_clear_flags
    );

    modport slave (
        input  train_start, rx_data, eye_early, eye_late, delay_out_of_range,
        output train_busy, train_done, train_fail, train_tap, delay_line_load,
               delay_line_move, delay_line_direction, eye_monitor_clear_flags
    );
`endif
endinterface

// File: rtl/dqsw_level_trainer.sv
// DDR4 DQSW write-leveling sequencer for one lane. Sweeps the IOD delay line
// tap by tap, majority-votes the DQ feedback at each tap and locks on the
// first low-to-high transition of the vote.
// Optional macro DQSW_EYE_QUAL_EN: discard samples flagged by the eye monitor,
// time out the tap after 2*SAMPLE_COUNT cycles and count discarded samples.
module dqsw_level_trainer #(
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned TAP_W         = 7,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLE_COUNT  = 16
) (
    input logic                FAB_CLK,
    input logic                RESET,
    dqsw_level_trainer_if.slave bus
);

    localparam int unsigned ONES_W  = $clog2(SAMPLE_COUNT + 1);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > 2 * SAMPLE_COUNT) ?
                                      SETTLE_CYCLES : 2 * SAMPLE_COUNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        StIdle, StLoad, StClear, StSettle, StSample, StEval, StStep, StDone, StFail
    } state_e;

    typedef enum logic {PhSeekLow, PhSeekHigh} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              load_pulse, move_pulse, clear_pulse;
    logic              hit, vote;

    assign hit = (bus.rx_data == 2'b11);

`ifdef DQSW_EYE_QUAL_EN
    logic [ONES_W-1:0] valid_q, valid_d;
    logic [7:0]        drops_q, drops_d;
    logic              eye_ok;

    assign eye_ok = !(bus.eye_early || bus.eye_late);
    // A tap that timed out without a full sample set always votes low.
    assign vote   = (valid_q == ONES_W'(SAMPLE_COUNT)) && (ones_q > ONES_W'(SAMPLE_COUNT / 2));
    assign bus.eye_qual_drops = drops_q;
`else
    assign vote = (ones_q > ONES_W'(SAMPLE_COUNT / 2));
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            phase_q <= PhSeekLow;
            tap_q   <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
`ifdef DQSW_EYE_QUAL_EN
            valid_q <= '0;
            drops_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
`ifdef DQSW_EYE_QUAL_EN
            valid_q <= valid_d;
            drops_q <= drops_d;
`endif
        end
    end

    // Next-state logic and IOD control pulse decode.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        tap_d       = tap_q;
        cnt_d       = cnt_q;
        ones_d      = ones_q;
        load_pulse  = 1'b0;
        move_pulse  = 1'b0;
        clear_pulse = 1'b0;
`ifdef DQSW_EYE_QUAL_EN
        valid_d     = valid_q;
        drops_d     = drops_q;
`endif
        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (bus.train_start) begin
                    state_d = StLoad;
                    tap_d   = '0;
                    phase_d = PhSeekLow;
`ifdef DQSW_EYE_QUAL_EN
                    drops_d = '0;
`endif
                end
            end
            StLoad: begin
                load_pulse = 1'b1;
                state_d    = StClear;
            end
            StClear: begin
                clear_pulse = 1'b1;
                cnt_d       = '0;
                state_d     = StSettle;
            end
            StSettle: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    ones_d  = '0;
`ifdef DQSW_EYE_QUAL_EN
                    valid_d = '0;
`endif
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSample: begin
`ifdef DQSW_EYE_QUAL_EN
                if (eye_ok) begin
                    if (hit) ones_d = ones_q + ONES_W'(1);
                    valid_d = valid_q + ONES_W'(1);
                end else if (drops_q != 8'hFF) begin
                    drops_d = drops_q + 8'd1;
                end
                if ((eye_ok && valid_q == ONES_W'(SAMPLE_COUNT - 1)) ||
                    cnt_q == CNT_W'(2 * SAMPLE_COUNT - 1)) begin
                    state_d = StEval;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (hit) ones_d = ones_q + ONES_W'(1);
                if (cnt_q == CNT_W'(SAMPLE_COUNT - 1)) begin
                    state_d = StEval;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            StEval: begin
                if (phase_q == PhSeekLow) begin
                    // A high vote before any low one is a previous clock edge; skip it.
                    if (!vote) phase_d = PhSeekHigh;
                    state_d = StStep;
                end else if (vote) begin
                    state_d = StDone;
                end else begin
                    state_d = StStep;
                end
            end
            StStep: begin
                // End-of-line check comes before the increment so the tap never wraps.
                if (bus.delay_out_of_range || tap_q == TAP_W'(MAX_TAPS - 1)) begin
                    state_d = StFail;
                end else begin
                    move_pulse = 1'b1;
                    tap_d      = tap_q + TAP_W'(1);
                    state_d    = StClear;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pulses are suppressed while reset is asserted.
    assign bus.delay_line_load         = load_pulse && !RESET;
    assign bus.delay_line_move         = move_pulse && !RESET;
    assign bus.eye_monitor_clear_flags = clear_pulse && !RESET;

    assign bus.train_busy           = !(state_q inside {StIdle, StDone, StFail});
    assign bus.train_done           = (state_q == StDone);
    assign bus.train_fail           = (state_q == StFail);
    assign bus.train_tap            = tap_q;
    assign bus.delay_line_direction = bus.train_busy;

endmodule

// File: tb/tb_dqsw_level_trainer.sv
// Randomized bench for dqsw_level_trainer: a cycle-level expected timeline is
// generated from per-tap sample counts, played into the DUT and compared every cycle.
module tb_dqsw_level_trainer;

    localparam int unsigned MAX_TAPS = 16;
    localparam int unsigned TAP_W    = 4;
    localparam int unsigned SETTLE   = 4;
    localparam int unsigned NSAMP    = 8;

    typedef struct {
        logic             rst, start, oor, early, late;
        logic [1:0]       rx;
        logic             busy, done, fail, dir, load, move, clr;
        logic [TAP_W-1:0] tap;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dqsw_level_trainer_if #(.TAP_W(TAP_W)) bus ();

    dqsw_level_trainer #(
        .MAX_TAPS     (MAX_TAPS),
        .TAP_W        (TAP_W),
        .SETTLE_CYCLES(SETTLE),
        .SAMPLE_COUNT (NSAMP)
    ) dut (
        .FAB_CLK(clk),
        .RESET  (rst),
        .bus    (bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    bit    chk_en = 1'b0;
    cyc_t  exp_c;
    int    n_load = 0, n_move = 0, n_clr = 0, n_busy = 0;
    bit    lit_valid = 1'b0;
    string lit_name;
    int    lit_act, lit_exp;

    // Model status carried between runs (what IDLE/DONE/FAIL should show)
    bit m_done = 1'b0, m_fail = 1'b0;
    int m_tap  = 0;

    // Compare process: DUT outputs against the timeline, plus literal checks.
    always @(negedge clk) begin
        logic [TAP_W+6:0] act, expv;
        if (chk_en) begin
            act  = {bus.train_busy, bus.train_done, bus.train_fail, bus.delay_line_direction,
                    bus.delay_line_load, bus.delay_line_move, bus.eye_monitor_clear_flags,
                    bus.train_tap};
            expv = {exp_c.busy, exp_c.done, exp_c.fail, exp_c.dir, exp_c.load, exp_c.move,
                    exp_c.clr, exp_c.tap};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL outputs cyc=%0d act=%b exp=%b (busy done fail dir load move clr tap)",
                         cyc, act, expv);
            end
            if (bus.delay_line_load) n_load++;
            if (bus.delay_line_move) n_move++;
            if (bus.eye_monitor_clear_flags) n_clr++;
            if (bus.train_busy) n_busy++;
        end
        if (lit_valid) begin
            checks++;
            if (lit_act != lit_exp) begin
                errors++;
                $display("FAIL %s act=%0d exp=%0d", lit_name, lit_act, lit_exp);
            end
        end
    end

    function automatic cyc_t base(input bit busy, input int t);
        cyc_t c;
        c.rst  = 1'b0;
        c.start = 1'b0;
        c.oor  = 1'b0;
`ifdef DQSW_EYE_QUAL_EN
        c.early = 1'b0;
        c.late  = 1'b0;
`else
        c.early = 1'($urandom_range(0, 1));
        c.late  = 1'($urandom_range(0, 1));
`endif
        c.rx   = 2'($urandom_range(0, 3));
        c.load = 1'b0;
        c.move = 1'b0;
        c.clr  = 1'b0;
        if (busy) begin
            c.busy  = 1'b1;
            c.done  = 1'b0;
            c.fail  = 1'b0;
            c.dir   = 1'b1;
            c.tap   = TAP_W'(t);
            c.start = ($urandom_range(0, 3) == 0);  // must be ignored while busy
        end else begin
            c.busy = 1'b0;
            c.done = m_done;
            c.fail = m_fail;
            c.dir  = 1'b0;
            c.tap  = TAP_W'(m_tap);
        end
        return c;
    endfunction

    // Timeline of one training run from per-tap count of 11 samples.
    task automatic build_run(input int ones_t[MAX_TAPS], input int oor_tap, input int rst_idx,
                             output cyc_t q[$]);
        cyc_t c;
        bit   found_low = 1'b0;
        bit   fin = 1'b0;
        bit   oor_now, vote;
        bit   s[NSAMP];
        q.delete();
        c = base(1'b0, 0);
        c.start = 1'b1;
        q.push_back(c);
        c = base(1'b1, 0);
        c.load = 1'b1;
        q.push_back(c);
        for (int t = 0; t < MAX_TAPS && !fin; t++) begin
            oor_now = (t >= oor_tap);
            c = base(1'b1, t);
            c.clr = 1'b1;
            c.oor = oor_now ? 1'b1 : 1'($urandom_range(0, 1));
            q.push_back(c);
            for (int k = 0; k < SETTLE; k++) begin
                c = base(1'b1, t);
                c.oor = oor_now ? 1'b1 : 1'($urandom_range(0, 1));
                q.push_back(c);
            end
            foreach (s[i]) s[i] = 1'b0;
            for (int k = 0; k < ones_t[t]; k++) begin
                int p;
                do p = $urandom_range(0, NSAMP - 1); while (s[p]);
                s[p] = 1'b1;
            end
            for (int k = 0; k < NSAMP; k++) begin
                c = base(1'b1, t);
                c.oor = oor_now ? 1'b1 : 1'($urandom_range(0, 1));
                c.rx  = s[k] ? 2'b11 : 2'($urandom_range(0, 2));
                q.push_back(c);
            end
            vote = (ones_t[t] > NSAMP / 2);
            c = base(1'b1, t);
            c.oor = oor_now ? 1'b1 : 1'($urandom_range(0, 1));
            q.push_back(c);
            if (found_low && vote) begin
                fin = 1'b1;
                m_done = 1'b1;
                m_fail = 1'b0;
                m_tap = t;
            end else begin
                if (!vote) found_low = 1'b1;
                c = base(1'b1, t);
                c.oor = oor_now;
                if (oor_now || t == MAX_TAPS - 1) begin
                    fin = 1'b1;
                    m_done = 1'b0;
                    m_fail = 1'b1;
                    m_tap = t;
                end else begin
                    c.move = 1'b1;
                end
                q.push_back(c);
            end
        end
        if (rst_idx >= 0 && rst_idx < q.size()) begin
            while (q.size() > rst_idx + 1) void'(q.pop_back());
            q[rst_idx].rst   = 1'b1;
            q[rst_idx].start = 1'b1;  // reset must win over start
            q[rst_idx].load  = 1'b0;
            q[rst_idx].move  = 1'b0;
            q[rst_idx].clr   = 1'b0;
            m_done = 1'b0;
            m_fail = 1'b0;
            m_tap  = 0;
        end
        for (int k = 0; k < 3; k++) q.push_back(base(1'b0, 0));
    endtask

    task automatic play(input cyc_t q[$]);
        foreach (q[i]) begin
            @(posedge clk);
            #1;
            rst                    = q[i].rst;
            bus.train_start        = q[i].start;
            bus.rx_data            = q[i].rx;
            bus.eye_early          = q[i].early;
            bus.eye_late           = q[i].late;
            bus.delay_out_of_range = q[i].oor;
            exp_c                  = q[i];
            chk_en                 = 1'b1;
            cyc++;
        end
    endtask

    task automatic lit(input string name, input int act, input int expv);
        @(posedge clk);
        #1;
        lit_name  = name;
        lit_act   = act;
        lit_exp   = expv;
        lit_valid = 1'b1;
        @(negedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    task automatic run_dir(input string name, input int ones_t[MAX_TAPS], input int oor_tap,
                           input int e_move, input int e_busy, input int e_tap, input bit e_done);
        cyc_t q[$];
        int   s_load, s_move, s_clr, s_busy;
        s_load = n_load;
        s_move = n_move;
        s_clr  = n_clr;
        s_busy = n_busy;
        build_run(ones_t, oor_tap, -1, q);
        play(q);
        lit({name, "_loads"}, n_load - s_load, 1);
        lit({name, "_moves"}, n_move - s_move, e_move);
        lit({name, "_clears"}, n_clr - s_clr, e_move + 1);
        lit({name, "_busy_cycles"}, n_busy - s_busy, e_busy);
        lit({name, "_tap"}, int'(bus.train_tap), e_tap);
        lit({name, "_done"}, int'(bus.train_done), int'(e_done));
        lit({name, "_fail"}, int'(bus.train_fail), int'(!e_done));
        lit({name, "_busy"}, int'(bus.train_busy), 0);
    endtask

    function automatic int lo();
        return $urandom_range(0, NSAMP / 2);
    endfunction

    function automatic int hi();
        return $urandom_range(NSAMP / 2 + 1, NSAMP);
    endfunction

    initial begin
        int   ot[MAX_TAPS];
        cyc_t q[$];
        bus.train_start        = 1'b0;
        bus.rx_data            = 2'b00;
        bus.eye_early          = 1'b0;
        bus.eye_late           = 1'b0;
        bus.delay_out_of_range = 1'b0;
        rst                    = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state
        q.delete();
        for (int k = 0; k < 2; k++) q.push_back(base(1'b0, 0));
        play(q);

        // Low at taps 0-4, high from 5
        foreach (ot[t]) ot[t] = (t < 5) ? lo() : hi();
        run_dir("s1", ot, 99, 5, 1 + 5 * 15 + 14, 5, 1'b1);

        // Initial high region skipped
        foreach (ot[t]) ot[t] = (t < 3 || t >= 7) ? hi() : lo();
        run_dir("s2", ot, 99, 7, 1 + 7 * 15 + 14, 7, 1'b1);

        // Never high: fail at the last tap
        foreach (ot[t]) ot[t] = lo();
        run_dir("s3", ot, 99, 15, 1 + 16 * 15, 15, 1'b0);

        // Out of range from tap 3
        foreach (ot[t]) ot[t] = lo();
        run_dir("s4", ot, 3, 3, 1 + 4 * 15, 3, 1'b0);

        // Vote threshold: 4 of 8 continues, 5 of 8 locks
        foreach (ot[t]) ot[t] = 8;
        ot[0] = 0;
        ot[1] = 4;
        ot[2] = 5;
        run_dir("s5a", ot, 99, 2, 1 + 2 * 15 + 14, 2, 1'b1);
        foreach (ot[t]) ot[t] = 0;
        ot[0] = 5;
        ot[1] = 4;
        ot[2] = 4;
        ot[3] = 5;
        run_dir("s5b", ot, 99, 3, 1 + 3 * 15 + 14, 3, 1'b1);

        // Reset mid-SAMPLE at tap 6, then a fresh run from tap 0
        foreach (ot[t]) ot[t] = lo();
        build_run(ot, 99, 2 + 15 * 6 + 5 + 3, q);
        play(q);
        lit("s6_tap", int'(bus.train_tap), 0);
        lit("s6_busy", int'(bus.train_busy), 0);
        foreach (ot[t]) ot[t] = (t < 2) ? lo() : hi();
        run_dir("s6_restart", ot, 99, 2, 1 + 2 * 15 + 14, 2, 1'b1);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            int oor_tap, rst_idx;
            foreach (ot[t]) ot[t] = $urandom_range(0, NSAMP);
            oor_tap = $urandom_range(0, 40);
            rst_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 150)) : -1;
            build_run(ot, oor_tap, rst_idx, q);
            play(q);
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
